// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Final pipeline stage. Accepts retiring instructions from
//               execute over a valid/ready handshake and drives the write port
//               of the 16x32 register bank. Loads wait for the data-memory
//               acknowledge, extract and extend the addressed byte, halfword
//               or word, and are aborted after a bounded number of wait
//               cycles. Committed register writes are counted.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage #(
  parameter int MEM_TIMEOUT = 16,  // max cycles in WAIT_MEM before abort (>=2)
  parameter int CNT_W       = 32   // width of retire_cnt
) (
  input  logic             clk,
  input  logic             rst,
  // execute-side handshake and instruction fields
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             ex_we,
  input  logic [3:0]       ex_wc,
  input  logic [31:0]      ex_result,
  input  logic             ex_load,
  input  logic [1:0]       ex_lsz,
  input  logic [1:0]       ex_loff,
  input  logic             ex_lsgn,
  // data-memory load return
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  // register bank write port
  output logic [3:0]       wc,
  output logic [31:0]      wpc,
  output logic             w_rb,
  // status
  output logic             err,
  output logic [CNT_W-1:0] retire_cnt
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] COMMIT   = 2'd2;

  localparam logic [1:0] LSZ_HALF = 2'b01;
  localparam logic [1:0] LSZ_BYTE = 2'b10;

  localparam int              TMO_W    = $clog2(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [TMO_W-1:0] tmo_cnt;

  // Fields of the instruction in flight. The load flag itself is not kept:
  // being in WAIT_MEM is what records that a load is pending, and the ALU
  // result is written straight into wpc at accept time.
  logic             lat_we;
  logic [3:0]       lat_wc;
  logic [1:0]       lat_lsz;
  logic [1:0]       lat_loff;
  logic             lat_lsgn;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic        accept;
  logic        tmo_hit;
  logic [15:0] half_lane;
  logic [7:0]  byte_lane;
  logic [31:0] load_data;

  assign accept  = ex_valid & ex_ready;
  assign tmo_hit = (state == WAIT_MEM) & ~mem_ack & (tmo_cnt == TMO_LAST);

  // Select the addressed lane and extend it to 32 bits; sizes 00 and 11 are words
  always_comb begin
    half_lane = lat_loff[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_loff)
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    case (lat_lsz)
      LSZ_HALF: load_data = {{16{lat_lsgn & half_lane[15]}}, half_lane};
      LSZ_BYTE: load_data = {{24{lat_lsgn & byte_lane[7]}}, byte_lane};
      default:  load_data = mem_rdata;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // Async reset returns to IDLE at once, dropping any pending load or commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  // IDLE and COMMIT both accept; WAIT_MEM resolves on ack (which beats timeout)
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE, COMMIT: begin
        if (accept) begin
          if (ex_load)    state_nxt = WAIT_MEM;
          else if (ex_we) state_nxt = COMMIT;
          else            state_nxt = IDLE;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT_MEM: begin
        if (mem_ack)      state_nxt = lat_we ? COMMIT : IDLE;
        else if (tmo_hit) state_nxt = IDLE;
        else              state_nxt = WAIT_MEM;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode
  // --------------------------------------------------------------------------
  // Write enable is a pure decode of the state register, so reset drops it immediately
  always_comb begin
    ex_ready = (state != WAIT_MEM);
    w_rb     = (state == COMMIT);
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  // Latch the accepted instruction, load the write port, and run the wait timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we   <= 1'b0;
      lat_wc   <= 4'd0;
      lat_lsz  <= 2'd0;
      lat_loff <= 2'd0;
      lat_lsgn <= 1'b0;
      wc       <= 4'd0;
      wpc      <= 32'd0;
      tmo_cnt  <= '0;
    end else begin
      if (accept) begin
        lat_we   <= ex_we;
        lat_wc   <= ex_wc;
        lat_lsz  <= ex_lsz;
        lat_loff <= ex_loff;
        lat_lsgn <= ex_lsgn;
        tmo_cnt  <= '0;
        // Non-load writes go straight to the port; silent retires leave it alone
        if (!ex_load && ex_we) begin
          wc  <= ex_wc;
          wpc <= ex_result;
        end
      end else if (state == WAIT_MEM) begin
        if (mem_ack) begin
          wc  <= lat_wc;
          wpc <= load_data;
        end else if (!tmo_hit) begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end
    end
  end

  // One-cycle error pulse in the cycle following a timed-out wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= tmo_hit;
    end
  end

  // Count every cycle the bank is written; wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (state == COMMIT) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Self-checking bench for writeback_stage. Table of single
//               instructions with hand-computed results, followed by
//               hand-written throughput and reset-during-operation sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 32;

  logic             clk;
  logic             rst;
  logic             ex_valid;
  logic             ex_ready;
  logic             ex_we;
  logic [3:0]       ex_wc;
  logic [31:0]      ex_result;
  logic             ex_load;
  logic [1:0]       ex_lsz;
  logic [1:0]       ex_loff;
  logic             ex_lsgn;
  logic             mem_ack;
  logic [31:0]      mem_rdata;
  logic [3:0]       wc;
  logic [31:0]      wpc;
  logic             w_rb;
  logic             err;
  logic [CNT_W-1:0] retire_cnt;

  writeback_stage #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_we      (ex_we),
    .ex_wc      (ex_wc),
    .ex_result  (ex_result),
    .ex_load    (ex_load),
    .ex_lsz     (ex_lsz),
    .ex_loff    (ex_loff),
    .ex_lsgn    (ex_lsgn),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .wc         (wc),
    .wpc        (wpc),
    .w_rb       (w_rb),
    .err        (err),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int model_cnt = 0;

  // ack_cyc: WAIT_MEM cycle (1-based) in which the ack is given; 0 = never
  typedef struct {
    logic        we;
    logic [3:0]  wcx;
    logic [31:0] result;
    logic        load;
    logic [1:0]  lsz;
    logic [1:0]  loff;
    logic        lsgn;
    logic [31:0] rdata;
    int          ack_cyc;
    logic        exp_wr;
    logic [31:0] exp_wpc;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  function automatic vec_t mk(logic we, logic [3:0] wcx, logic [31:0] result, logic load,
                              logic [1:0] lsz, logic [1:0] loff, logic lsgn,
                              logic [31:0] rdata, int ack_cyc, logic exp_wr,
                              logic [31:0] exp_wpc, logic exp_err);
    vec_t v;
    v.we = we; v.wcx = wcx; v.result = result; v.load = load; v.lsz = lsz;
    v.loff = loff; v.lsgn = lsgn; v.rdata = rdata; v.ack_cyc = ack_cyc;
    v.exp_wr = exp_wr; v.exp_wpc = exp_wpc; v.exp_err = exp_err;
    return v;
  endfunction

  // Issue one instruction, run its memory phase, and check the result cycle
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    @(negedge clk);
    chk($sformatf("v%0d ready_before", idx), 32'(ex_ready), 32'd1);
    ex_valid  = 1'b1;
    ex_we     = v.we;
    ex_wc     = v.wcx;
    ex_result = v.result;
    ex_load   = v.load;
    ex_lsz    = v.lsz;
    ex_loff   = v.loff;
    ex_lsgn   = v.lsgn;
    mem_rdata = v.rdata;
    mem_ack   = 1'b0;
    @(negedge clk);
    ex_valid  = 1'b0;
    ex_result = 32'h5A5A_5A5A;
    if (v.load) begin
      n = (v.ack_cyc == 0) ? MEM_TIMEOUT : v.ack_cyc;
      for (int i = 1; i <= n; i++) begin
        chk($sformatf("v%0d ready_wait%0d", idx, i), 32'(ex_ready), 32'd0);
        chk($sformatf("v%0d wrb_wait%0d", idx, i), 32'(w_rb), 32'd0);
        if (i == v.ack_cyc) mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
      end
    end
    chk($sformatf("v%0d w_rb", idx), 32'(w_rb), 32'(v.exp_wr));
    chk($sformatf("v%0d err", idx), 32'(err), 32'(v.exp_err));
    if (v.exp_wr) begin
      chk($sformatf("v%0d wc", idx), 32'(wc), 32'(v.wcx));
      chk($sformatf("v%0d wpc", idx), wpc, v.exp_wpc);
      model_cnt++;
    end
    @(negedge clk);
    chk($sformatf("v%0d w_rb_after", idx), 32'(w_rb), 32'd0);
    chk($sformatf("v%0d err_after", idx), 32'(err), 32'd0);
    chk($sformatf("v%0d retire_cnt", idx), retire_cnt, 32'(model_cnt));
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_we = 1'b0; ex_wc = 4'd0; ex_result = 32'd0;
    ex_load = 1'b0; ex_lsz = 2'd0; ex_loff = 2'd0; ex_lsgn = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'd0;

    //           we  wc     result         ld  lsz    loff   sgn  rdata          ack wr  exp_wpc        err
    vecs.push_back(mk(1, 4'd5, 32'hDEADBEEF, 0, 2'b00, 2'd0, 0, 32'h0,          0, 1, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 4'd3, 32'h0,        1, 2'b10, 2'd2, 1, 32'h0080_0000,  3, 1, 32'hFFFFFF80, 0));
    vecs.push_back(mk(1, 4'd3, 32'h0,        1, 2'b10, 2'd2, 0, 32'h0080_0000,  3, 1, 32'h00000080, 0));
    vecs.push_back(mk(1, 4'd7, 32'h0,        1, 2'b01, 2'd2, 0, 32'h8001_1234,  1, 1, 32'h00008001, 0));
    vecs.push_back(mk(1, 4'd8, 32'h0,        1, 2'b01, 2'd0, 1, 32'h8001_9234,  2, 1, 32'hFFFF9234, 0));
    vecs.push_back(mk(1, 4'd2, 32'h0,        1, 2'b00, 2'd3, 1, 32'hCAFE_F00D,  1, 1, 32'hCAFEF00D, 0));
    vecs.push_back(mk(1, 4'd4, 32'h0,        1, 2'b11, 2'd1, 1, 32'h8234_5678,  2, 1, 32'h82345678, 0));
    vecs.push_back(mk(1, 4'd6, 32'h0,        1, 2'b10, 2'd0, 1, 32'hFFFF_FF7F,  1, 1, 32'h0000007F, 0));
    vecs.push_back(mk(1, 4'd10,32'h0,        1, 2'b10, 2'd1, 1, 32'h0000_A500,  1, 1, 32'hFFFFFFA5, 0));
    vecs.push_back(mk(1, 4'd11,32'h0,        1, 2'b10, 2'd3, 0, 32'h9A00_0000,  1, 1, 32'h0000009A, 0));
    vecs.push_back(mk(1, 4'd12,32'h0,        1, 2'b00, 2'd0, 0, 32'h1111_2222,  0, 0, 32'h0,        1));
    vecs.push_back(mk(1, 4'd9, 32'h0,        1, 2'b00, 2'd0, 0, 32'h1122_3344, 16, 1, 32'h11223344, 0));
    vecs.push_back(mk(0, 4'd13,32'h77777777, 0, 2'b00, 2'd0, 0, 32'h0,          0, 0, 32'h0,        0));
    vecs.push_back(mk(0, 4'd14,32'h0,        1, 2'b00, 2'd0, 0, 32'hABCD_0000,  2, 0, 32'h0,        0));
    vecs.push_back(mk(1, 4'd15,32'h0,        1, 2'b01, 2'd3, 1, 32'h7FFF_0000, 15, 1, 32'h00007FFF, 0));

    // Reset state, both while held and just after release
    repeat (2) @(negedge clk);
    chk("rst w_rb", 32'(w_rb), 32'd0);
    chk("rst wc", 32'(wc), 32'd0);
    chk("rst wpc", wpc, 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst retire_cnt", retire_cnt, 32'd0);
    chk("rst ex_ready", 32'(ex_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst w_rb", 32'(w_rb), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Four back-to-back ALU writes to r1..r4: one commit per cycle
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) begin
        chk($sformatf("b2b w_rb%0d", i - 1), 32'(w_rb), 32'd1);
        chk($sformatf("b2b wc%0d", i - 1), 32'(wc), 32'(i - 1));
        chk($sformatf("b2b wpc%0d", i - 1), wpc, 32'h1000_0000 + 32'(i - 1));
      end
      chk($sformatf("b2b ready%0d", i), 32'(ex_ready), 32'd1);
      if (i <= 4) begin
        ex_valid = 1'b1; ex_we = 1'b1; ex_load = 1'b0;
        ex_wc = 4'(i); ex_result = 32'h1000_0000 + 32'(i);
      end else begin
        ex_valid = 1'b0;
      end
      @(negedge clk);
    end
    model_cnt += 4;
    chk("b2b w_rb_end", 32'(w_rb), 32'd0);
    chk("b2b retire_cnt", retire_cnt, 32'(model_cnt));

    // Reset during WAIT_MEM, with an ack arriving while reset is held
    @(negedge clk);
    ex_valid = 1'b1; ex_we = 1'b1; ex_wc = 4'd12; ex_load = 1'b1; ex_lsz = 2'b00;
    mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    chk("rstld ready_wait", 32'(ex_ready), 32'd0);
    #2 rst = 1'b1; mem_ack = 1'b1;
    #1;
    chk("rstld wc", 32'(wc), 32'd0);
    chk("rstld wpc", wpc, 32'd0);
    chk("rstld retire_cnt", retire_cnt, 32'd0);
    chk("rstld ready", 32'(ex_ready), 32'd1);
    model_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstld post w_rb%0d", i), 32'(w_rb), 32'd0);
      chk($sformatf("rstld post ready%0d", i), 32'(ex_ready), 32'd1);
    end
    chk("rstld post retire_cnt", retire_cnt, 32'd0);

    // Reset during COMMIT drops the write enable immediately
    ex_valid = 1'b1; ex_we = 1'b1; ex_wc = 4'd6; ex_load = 1'b0; ex_result = 32'h6666_6666;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("rstcm w_rb_before", 32'(w_rb), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstcm w_rb", 32'(w_rb), 32'd0);
    chk("rstcm wc", 32'(wc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstcm post w_rb", 32'(w_rb), 32'd0);
    chk("rstcm post retire_cnt", retire_cnt, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
